prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter WIDTH, default 5: length of the checker shift register; matches the generator length.
REQ-002 Parameter LOCK_CNT, default 8: consecutive correct predictions needed to declare lock.
REQ-003 Parameter LOSS_ERRS, default 4: mismatches within one loss window that force loss of lock.
REQ-004 Parameter WIN_LEN, default 32: loss window length, in valid bits.
REQ-005 Parameter ERR_W, default 16: width of the error counter.
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 Port in_valid, input, 1 bit: in_bit is a new stream bit this cycle.
REQ-009 Port in_bit, input, 1 bit: serial bit, taken from the generator's out (its state bit 0).
REQ-010 Port taps, input, WIDTH bits: feedback mask, used live each cycle and never latched.
REQ-011 Port clear_errs, input, 1 bit: synchronous clear of err_count.
REQ-012 Port sync_state, output, 2 bits: 0=HUNT, 1=VERIFY, 2=LOCKED.
REQ-013 Port locked, output, 1 bit: high exactly when sync_state==LOCKED.
REQ-014 Port err_pulse, output, 1 bit: one-cycle registered flag for a mismatch counted in LOCKED.
REQ-015 Port err_count, output, ERR_W bits: saturating count of mismatches in LOCKED.

Function
REQ-016 The checker SHALL keep shift register sr[WIDTH-1:0] and compute pred = XOR-reduce(sr & taps); shift = {sr[WIDTH-2:0], b}, where b is defined per state.
REQ-017 When in_valid=0, all registers SHALL hold, except the clear_errs effect.
REQ-018 HUNT: on each valid bit, sr SHALL shift with b=in_bit and the fill counter increments; after WIDTH valid bits, go to VERIFY with match count 0.
REQ-019 VERIFY: on each valid bit, sr SHALL shift with b=in_bit.
REQ-020 VERIFY: in_bit==pred increments the match count; in_bit!=pred resets it to 0 and stays in VERIFY.
REQ-021 VERIFY->LOCKED SHALL occur on the valid bit that brings the match count to LOCK_CNT, provided the post-shift sr is nonzero; otherwise reset the match count to 0 and stay in VERIFY.
REQ-022 LOCKED (flywheel): sr SHALL shift with b=pred, so a single flipped input bit costs exactly one error.
REQ-023 LOCKED mismatch SHALL assert err_pulse for the next cycle, increment err_count (saturating at all-ones), and increment the window error count.
REQ-024 Window: a WIN_LEN-bit counter SHALL advance on each valid bit in LOCKED; at wrap, the window error count is cleared.
REQ-025 When the window error count reaches LOSS_ERRS, the FSM SHALL go to HUNT with fill count 0; that mismatch is still counted.
REQ-026 If a wrap and the LOSS_ERRS-th error fall on the same bit, loss SHALL take priority.
REQ-027 clear_errs SHALL zero err_count next edge; a simultaneous mismatch is discarded (clear wins). State is unaffected.
REQ-028 A taps change SHALL take effect on the next valid bit's prediction; no implicit resync.
REQ-029 Each state SHALL persist until one of REQ-018 to REQ-025 changes it; no other transitions.

Reset
REQ-030 rst high SHALL asynchronously force: sync_state=HUNT; sr, fill, match and window counters=0; locked=0; err_pulse=0; err_count=0.
REQ-031 Reset asserted mid-lock SHALL discard lock; after release, reacquisition SHALL take WIDTH+LOCK_CNT valid bits.

Verification
REQ-032 Acquisition: taps=10100, stream from generator seeded 11010, in_valid=1 continuously -> locked rises on valid bit 13 (5+8); err_count=0 through 100 bits.
REQ-033 Single error: after lock, invert one bit -> err_pulse exactly once, err_count=1, locked stays 1.
REQ-034 Loss: after lock, invert 4 bits within 32 -> HUNT after the 4th, err_count=4; clean stream then relocks 13 bits later.
REQ-035 All-zero stream, any taps -> never leaves VERIFY; locked=0 indefinitely.
REQ-036 Gaps and clear: in_valid toggled 1/0 during acquisition -> lock after 13 valid bits; clear_errs together with a mismatch -> err_count=0.
REQ-037 Async reset: rst pulsed mid-cycle while locked -> outputs zero immediately, before the next clk edge.

Source files
------------

// File: rtl/prbs_checker.sv
// Serial PRBS checker: acquires lock on a Fibonacci LFSR stream, then flywheels on its own
// prediction so each corrupted input bit costs exactly one counted error.
module prbs_checker #(
    parameter int unsigned WIDTH     = 5,
    parameter int unsigned LOCK_CNT  = 8,
    parameter int unsigned LOSS_ERRS = 4,
    parameter int unsigned WIN_LEN   = 32,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] taps,
    input  logic             clear_errs,
    output logic [1:0]       sync_state,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned FillW  = $clog2(WIDTH + 1);
    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WinW   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned WerrW  = $clog2(LOSS_ERRS + 1);

    localparam logic [FillW-1:0]  FillLast  = FillW'(WIDTH - 1);
    localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
    localparam logic [WinW-1:0]   WinLast   = WinW'(WIN_LEN - 1);
    localparam logic [WerrW-1:0]  WerrLast  = WerrW'(LOSS_ERRS - 1);

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StVerify = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [FillW-1:0]   fill_q, fill_d;
    logic [MatchW-1:0]  match_q, match_d;
    logic [WinW-1:0]    win_q, win_d;
    logic [WerrW-1:0]   werr_q, werr_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic             pred;
    logic             mismatch;
    logic [WIDTH-1:0] sr_in;

    assign pred     = ^(sr_q & taps);
    assign mismatch = in_bit ^ pred;
    assign sr_in    = {sr_q[WIDTH-2:0], in_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHunt;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (in_valid) begin
            unique case (state_q)
                StHunt: begin
                    sr_d = sr_in;
                    if (fill_q == FillLast) begin
                        state_d = StVerify;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FillW'(1);
                    end
                end
                StVerify: begin
                    sr_d = sr_in;
                    if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == MatchLast) begin
                        // An all-zero register would predict zeros forever; refuse to lock on it.
                        match_d = '0;
                        if (sr_in != '0) begin
                            state_d = StLocked;
                            win_d   = '0;
                            werr_d  = '0;
                        end
                    end else begin
                        match_d = match_q + MatchW'(1);
                    end
                end
                StLocked: begin
                    sr_d  = {sr_q[WIDTH-2:0], pred};
                    win_d = (win_q == WinLast) ? '0 : win_q + WinW'(1);
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                    // Loss outranks the window wrap on the same bit.
                    if (mismatch && (werr_q == WerrLast)) begin
                        state_d = StHunt;
                        fill_d  = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WinLast) begin
                        werr_d = '0;
                    end else if (mismatch) begin
                        werr_d = werr_q + WerrW'(1);
                    end
                end
                default: begin
                    state_d = StHunt;
                    fill_d  = '0;
                end
            endcase
        end

        if (clear_errs) begin
            err_cnt_d = '0;
        end
    end

    always_comb begin
        sync_state = state_q;
        locked     = (state_q == StLocked);
        err_pulse  = err_pulse_q;
        err_count  = err_cnt_q;
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: table of stimulus phases driven from an LFSR generator model, with
// expected outputs queued at drive time and compared after each clock edge.
module tb_prbs_checker;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_bit;
    logic [W-1:0] taps;
    logic         clear_errs;
    logic [1:0]   sync_state;
    logic         locked;
    logic         err_pulse;
    logic [15:0]  err_count;

    always #5 clk = ~clk;

    prbs_checker #(
        .WIDTH    (5),
        .LOCK_CNT (8),
        .LOSS_ERRS(4),
        .WIN_LEN  (32),
        .ERR_W    (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .taps      (taps),
        .clear_errs(clear_errs),
        .sync_state(sync_state),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    typedef struct {
        string       name;
        logic        chk_pulse;
        logic [1:0]  st;
        logic        pulse;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        string       name;
        int unsigned nbits;
        logic        flip;
        logic        clr;
        logic        chk_pulse;
        logic [1:0]  st;
        logic        pulse;
        logic [15:0] cnt;
    } phase_t;

    exp_t   sb_q[$];
    phase_t tbl[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic [W-1:0] gen_q;

    // Generator: out is state bit 0, state shifts left taking XOR of tapped bits.
    function automatic logic gen_next();
        logic b;
        b     = gen_q[0];
        gen_q = {gen_q[W-2:0], ^(gen_q & taps)};
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input string name, input logic chkp, input logic [1:0] st,
                                    input logic p, input logic [15:0] c);
        exp_t e;
        e.name      = name;
        e.chk_pulse = chkp;
        e.st        = st;
        e.pulse     = p;
        e.cnt       = c;
        return e;
    endfunction

    task automatic add(input string name, input int unsigned n, input logic flip, input logic clr,
                       input logic chkp, input logic [1:0] st, input logic p,
                       input logic [15:0] c);
        phase_t ph;
        ph.name = name; ph.nbits = n; ph.flip = flip; ph.clr = clr;
        ph.chk_pulse = chkp; ph.st = st; ph.pulse = p; ph.cnt = c;
        tbl.push_back(ph);
    endtask

    task automatic step(input logic v, input logic b, input logic clr, input logic do_chk,
                        input exp_t e);
        exp_t x;
        in_valid   = v;
        in_bit     = b;
        clear_errs = clr;
        if (do_chk) sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (do_chk && sb_q.size() != 0) begin
            x = sb_q.pop_front();
            check({x.name, "/state"}, 32'(sync_state), 32'(x.st));
            check({x.name, "/locked"}, 32'(locked), 32'(x.st == 2'd2));
            if (x.chk_pulse) check({x.name, "/err_pulse"}, 32'(err_pulse), 32'(x.pulse));
            check({x.name, "/err_count"}, 32'(err_count), 32'(x.cnt));
        end
    endtask

    function automatic logic [1:0] acq_state(input int k);
        return (k < 5) ? 2'd0 : ((k < 13) ? 2'd1 : 2'd2);
    endfunction

    initial begin
        logic b;
        logic [W-1:0] ztaps [3];

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear_errs = 1'b0;
        taps  = 5'b10100;
        gen_q = 5'b11010;
        repeat (2) @(posedge clk);
        #1;
        check("reset/state", 32'(sync_state), 32'd0);
        check("reset/locked", 32'(locked), 32'd0);
        check("reset/err_pulse", 32'(err_pulse), 32'd0);
        check("reset/err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_exp("idle_after_reset", 1'b1, 2'd0, 1'b0, 16'd0));

        // Phases: LOCKED bits are numbered from 0 after the lock bit; window wraps at 31.
        add("hunt_4bits",     4,  0, 0, 1, 2'd0, 0, 16'd0);
        add("verify_5th",     1,  0, 0, 1, 2'd1, 0, 16'd0);
        add("verify_12th",    7,  0, 0, 1, 2'd1, 0, 16'd0);
        add("lock_13th",      1,  0, 0, 1, 2'd2, 0, 16'd0);
        add("locked_clean20", 20, 0, 0, 1, 2'd2, 0, 16'd0);
        add("single_err",     1,  1, 0, 1, 2'd2, 1, 16'd1);
        add("pulse_once",     1,  0, 0, 1, 2'd2, 0, 16'd1);
        add("clean6",         6,  0, 0, 1, 2'd2, 0, 16'd1);
        add("win_err_a",      1,  1, 0, 1, 2'd2, 1, 16'd2);
        add("win_err_b",      1,  1, 0, 1, 2'd2, 1, 16'd3);
        add("pre_wrap",       2,  0, 0, 1, 2'd2, 0, 16'd3);
        add("next_win_e1",    1,  1, 0, 1, 2'd2, 1, 16'd4);
        add("next_win_e2",    1,  1, 0, 1, 2'd2, 1, 16'd5);
        add("next_win_e3",    1,  1, 0, 1, 2'd2, 1, 16'd6);
        add("loss_4th",       1,  1, 0, 1, 2'd0, 1, 16'd7);
        add("refill_12",      12, 0, 0, 1, 2'd1, 0, 16'd7);
        add("relock_13",      1,  0, 0, 1, 2'd2, 0, 16'd7);
        add("clear_vs_err",   1,  1, 1, 0, 2'd2, 0, 16'd0);
        add("after_clear",    1,  0, 0, 1, 2'd2, 0, 16'd0);
        add("err_before_rst", 1,  1, 0, 1, 2'd2, 1, 16'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < int'(tbl[i].nbits); k++) begin
                logic last;
                last = (k == int'(tbl[i].nbits) - 1);
                b = gen_next();
                if (last && tbl[i].flip) b = ~b;
                step(1'b1, b, last && tbl[i].clr, last,
                     mk_exp(tbl[i].name, tbl[i].chk_pulse, tbl[i].st, tbl[i].pulse, tbl[i].cnt));
            end
        end

        // Asynchronous reset mid-cycle while locked with a pending pulse and nonzero count.
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst/state", 32'(sync_state), 32'd0);
        check("async_rst/locked", 32'(locked), 32'd0);
        check("async_rst/err_pulse", 32'(err_pulse), 32'd0);
        check("async_rst/err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reacquire with in_valid toggling; idle cycles must not advance anything.
        for (int k = 1; k <= 13; k++) begin
            step(1'b0, 1'($urandom), 1'b0, 1'b1,
                 mk_exp("gap_idle", 1'b1, acq_state(k - 1), 1'b0, 16'd0));
            step(1'b1, gen_next(), 1'b0, 1'b1,
                 mk_exp("gap_valid", 1'b1, acq_state(k), 1'b0, 16'd0));
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, mk_exp("gap_hold_locked", 1'b1, 2'd2, 1'b0, 16'd0));

        // All-zero stream never locks, whatever the taps.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ztaps[0] = 5'b10100;
        ztaps[1] = 5'b11111;
        ztaps[2] = 5'b00001;
        for (int t = 0; t < 3; t++) begin
            taps = ztaps[t];
            for (int k = 0; k < 40; k++) begin
                step(1'b1, 1'b0, 1'b0, k == 39,
                     mk_exp("zero_stream", 1'b1, 2'd1, 1'b0, 16'd0));
            end
        end

        in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
